// File: rtl/sa_operand_feeder.sv
// sa_operand_feeder: transmit side of the PE operand interface for an N x N
// systolic array. Accepts one k-slice per beat, skews lane i by 1+i register
// stages, generates the per-row init pulse for the first beat of a tile, and
// flags tile completion when the last skewed operand leaves lane N-1.
module sa_operand_feeder #(
    parameter int D_W   = 32,
    parameter int N     = 4,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic               s_last,
    input  logic [N*D_W-1:0]   s_a,
    input  logic [N*D_W-1:0]   s_b,
    output logic [N*D_W-1:0]   out_a,
    output logic [N*D_W-1:0]   out_b,
    output logic [N-1:0]       out_init,
    output logic               tile_done,
    output logic [CNT_W-1:0]   k_count,
    output logic               busy
);

    localparam int DC_W = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DRAIN
    } state_t;

    state_t            state_q, state_d;
    logic [DC_W-1:0]   drain_q, drain_d;
    logic [CNT_W-1:0]  kcnt_q, kcnt_d;
    logic              done_q, done_d;
    logic              accept;
    logic              first_beat;

    assign s_ready   = (state_q != DRAIN);
    assign accept    = s_valid & s_ready;
    assign busy      = (state_q != IDLE);
    assign tile_done = done_q;
    assign k_count   = kcnt_q;

    // Control state, drain counter, beat counter and completion pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            drain_q <= '0;
            kcnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            kcnt_q  <= kcnt_d;
            done_q  <= done_d;
        end
    end

    // Next-state logic: tile start/end handling and the drain countdown.
    // tile_done is raised on the edge that leaves DRAIN, which is the same
    // edge that loads the tile's last beat into lane N-1's final stage.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        kcnt_d     = kcnt_q;
        done_d     = 1'b0;
        first_beat = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    first_beat = 1'b1;
                    kcnt_d     = CNT_W'(1);
                    if (s_last) begin
                        state_d = DRAIN;
                        drain_d = DC_W'(N - 1);
                    end else begin
                        state_d = ACTIVE;
                    end
                end
            end
            ACTIVE: begin
                if (accept) begin
                    if (kcnt_q != '1) begin
                        kcnt_d = kcnt_q + CNT_W'(1);
                    end
                    if (s_last) begin
                        state_d = DRAIN;
                        drain_d = DC_W'(N - 1);
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q - DC_W'(1);
                if (drain_q == DC_W'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [D_W-1:0] a_q [0:i];
        logic [D_W-1:0] a_d [0:i];
        logic [D_W-1:0] b_q [0:i];
        logic [D_W-1:0] b_d [0:i];
        logic [i:0]     init_q, init_d;

        // Skew chain input: accepted data or zero bubble, then shift.
        always_comb begin
            a_d[0]    = accept ? s_a[i*D_W +: D_W] : '0;
            b_d[0]    = accept ? s_b[i*D_W +: D_W] : '0;
            init_d    = '0;
            init_d[0] = first_beat;
            for (int unsigned s = 1; s <= i; s++) begin
                a_d[s]    = a_q[s-1];
                b_d[s]    = b_q[s-1];
                init_d[s] = init_q[s-1];
            end
        end

        // Skew chain registers for lane i (1+i stages).
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int unsigned s = 0; s <= i; s++) begin
                    a_q[s] <= '0;
                    b_q[s] <= '0;
                end
                init_q <= '0;
            end else begin
                a_q    <= a_d;
                b_q    <= b_d;
                init_q <= init_d;
            end
        end

        assign out_a[i*D_W +: D_W] = a_q[i];
        assign out_b[i*D_W +: D_W] = b_q[i];
        assign out_init[i]         = init_q[i];
    end

endmodule
